// File: rtl/gzip_pkg.sv
// Shared types and helpers for the GZIP framing stages.
package gzip_pkg;

  typedef enum logic [1:0] {
    ST_COUNT    = 2'd0,
    ST_WAIT_CRC = 2'd1,
    ST_EMIT     = 2'd2
  } state_e;

  localparam int unsigned GZIP_TRAILER_BYTES = 8;
  localparam int unsigned TRL_IDX_W          = 3;

  typedef logic [TRL_IDX_W-1:0] trl_idx_t;

  // Select trailer byte idx from {isize, crc}, both little-endian.
  function automatic logic [7:0] trailer_byte(input logic [31:0] crc,
                                              input logic [31:0] isize,
                                              input trl_idx_t    idx);
    logic [63:0] frame;
    frame = {isize, crc};
    return frame[{idx, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/gzip_trailer_gen.sv
// GZIP trailer generator: counts stream bytes, latches the final CRC32 and
// emits CRC32 then ISIZE (both little-endian) as eight valid/ready bytes.
module gzip_trailer_gen
  import gzip_pkg::*;
#(
  parameter int unsigned ISIZE_W = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        data_valid_in,
  input  logic        data_last_in,
  input  logic        flush_in,
  input  logic [31:0] crc32_in,
  output logic [7:0]  trl_data_out,
  output logic        trl_valid_out,
  input  logic        trl_ready_in,
  output logic        busy_out,
  output logic        done_out,
  output logic        protocol_err_out
);

  localparam trl_idx_t LAST_IDX = trl_idx_t'(GZIP_TRAILER_BYTES - 1);

  state_e             state_q, state_d;
  logic [ISIZE_W-1:0] count_q, count_d;
  logic [31:0]        crc_q, crc_d;
  trl_idx_t           idx_q, idx_d;
  logic [7:0]         data_q, data_d;
  logic               valid_q, valid_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               err_q, err_d;

  logic [31:0]        isize;
  logic               stream_in;
  logic               handshake;
  trl_idx_t           idx_next;

  assign isize     = 32'(count_q);
  assign stream_in = data_valid_in | flush_in;
  assign handshake = valid_q & trl_ready_in;
  assign idx_next  = trl_idx_t'(idx_q + trl_idx_t'(1));

  // Next-state, byte counting and trailer sequencing.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    crc_d   = crc_q;
    idx_d   = idx_q;
    data_d  = data_q;
    valid_d = valid_q;
    done_d  = 1'b0;
    err_d   = err_q;

    case (state_q)
      ST_COUNT: begin
        if (data_valid_in) begin
          count_d = count_q + ISIZE_W'(1);
          if (data_last_in || flush_in) begin
            state_d = ST_WAIT_CRC;
          end
        end else if (flush_in) begin
          state_d = ST_WAIT_CRC;
        end
      end

      ST_WAIT_CRC: begin
        // crc32 settled on the edge that took the last byte; capture it now.
        if (stream_in) begin
          err_d = 1'b1;
        end
        crc_d   = crc32_in;
        idx_d   = '0;
        data_d  = crc32_in[7:0];
        valid_d = 1'b1;
        state_d = ST_EMIT;
      end

      ST_EMIT: begin
        if (stream_in) begin
          err_d = 1'b1;
        end
        if (handshake) begin
          if (idx_q == LAST_IDX) begin
            valid_d = 1'b0;
            done_d  = 1'b1;
            count_d = '0;
            idx_d   = '0;
            data_d  = '0;
            state_d = ST_COUNT;
          end else begin
            idx_d  = idx_next;
            data_d = trailer_byte(crc_q, isize, idx_next);
          end
        end
      end

      default: begin
        state_d = ST_COUNT;
      end
    endcase

    busy_d = (state_d != ST_COUNT);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_COUNT;
      count_q <= '0;
      crc_q   <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      crc_q   <= crc_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign trl_data_out     = data_q;
  assign trl_valid_out    = valid_q;
  assign busy_out         = busy_q;
  assign done_out         = done_q;
  assign protocol_err_out = err_q;

endmodule

// File: tb/tb_gzip_trailer_gen.sv
// Directed bench for gzip_trailer_gen; a second instance with an 8-bit
// counter shares the stimulus to exercise ISIZE wrap.
module tb_gzip_trailer_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        data_valid_in;
  logic        data_last_in;
  logic        flush_in;
  logic [31:0] crc32_in;
  logic        trl_ready_in;

  logic [7:0]  trl_data_out,  trl_data_out_8;
  logic        trl_valid_out, trl_valid_out_8;
  logic        busy_out,      busy_out_8;
  logic        done_out,      done_out_8;
  logic        protocol_err_out, protocol_err_out_8;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  gzip_trailer_gen #(.ISIZE_W(32)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .data_valid_in    (data_valid_in),
    .data_last_in     (data_last_in),
    .flush_in         (flush_in),
    .crc32_in         (crc32_in),
    .trl_data_out     (trl_data_out),
    .trl_valid_out    (trl_valid_out),
    .trl_ready_in     (trl_ready_in),
    .busy_out         (busy_out),
    .done_out         (done_out),
    .protocol_err_out (protocol_err_out)
  );

  gzip_trailer_gen #(.ISIZE_W(8)) dut8 (
    .clk              (clk),
    .rst_n            (rst_n),
    .data_valid_in    (data_valid_in),
    .data_last_in     (data_last_in),
    .flush_in         (flush_in),
    .crc32_in         (crc32_in),
    .trl_data_out     (trl_data_out_8),
    .trl_valid_out    (trl_valid_out_8),
    .trl_ready_in     (trl_ready_in),
    .busy_out         (busy_out_8),
    .done_out         (done_out_8),
    .protocol_err_out (protocol_err_out_8)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_data"},  trl_data_out,     0);
    check({tag, "_valid"}, trl_valid_out,    0);
    check({tag, "_busy"},  busy_out,         0);
    check({tag, "_done"},  done_out,         0);
    check({tag, "_err"},   protocol_err_out, 0);
  endtask

  // Drive n strobed bytes (n==0 -> bare flush); ends just after the last-byte edge.
  task automatic send_stream(input string name, input int n, input logic flush_last,
                             input logic [31:0] crc);
    crc32_in = crc;
    if (n == 0) begin
      flush_in = 1'b1;
      tick();
      flush_in = 1'b0;
    end else begin
      for (int i = 0; i < n; i++) begin
        data_valid_in = 1'b1;
        if (i == n - 1) begin
          if (flush_last) flush_in = 1'b1;
          else            data_last_in = 1'b1;
        end
        tick();
      end
      data_valid_in = 1'b0;
      data_last_in  = 1'b0;
      flush_in      = 1'b0;
    end
    check({name, "_busy_wait"},  busy_out,      1);
    check({name, "_valid_wait"}, trl_valid_out, 0);
  endtask

  // Collect nbytes trailer bytes; ready_mode 0 = always ready, 1 = 1-0-0-1 pattern.
  task automatic collect(input string name, input int nbytes, input int ready_mode,
                         input int inject_at, input logic [63:0] exp, input logic [63:0] exp8);
    logic [63:0] got, got8;
    logic [3:0]  pat;
    logic        pv, phs;
    logic [7:0]  pd;
    int          k, cyc;
    got = '0; got8 = '0; pat = 4'b1001;
    pv = 1'b0; phs = 1'b0; pd = '0; k = 0; cyc = 0;
    tick();
    check({name, "_valid_first"}, trl_valid_out, 1);
    while (k < nbytes && cyc < 200) begin
      trl_ready_in  = (ready_mode == 0) ? 1'b1 : pat[cyc % 4];
      data_valid_in = (cyc == inject_at);
      if (pv && !phs) check({name, "_hold"}, trl_data_out, pd);
      check({name, "_valid_held"}, trl_valid_out, 1);
      phs = trl_valid_out & trl_ready_in;
      pv  = trl_valid_out;
      pd  = trl_data_out;
      if (phs) begin
        got[8*k +: 8]  = trl_data_out;
        got8[8*k +: 8] = trl_data_out_8;
        k++;
      end
      tick();
      cyc++;
    end
    data_valid_in = 1'b0;
    trl_ready_in  = 1'b0;
    if (k < nbytes) check({name, "_timeout_bytes"}, 64'(k), 64'(nbytes));
    check({name, "_trailer"},   got,  exp);
    check({name, "_trailer8"},  got8, exp8);
    if (nbytes == 8) begin
      check({name, "_done"},       done_out,      1);
      check({name, "_done8"},      done_out_8,    1);
      check({name, "_valid_end"},  trl_valid_out, 0);
      check({name, "_busy_end"},   busy_out,      0);
      tick();
      check({name, "_done_once"},  done_out,      0);
    end
  endtask

  initial begin
    rst_n = 1'b0; data_valid_in = 1'b0; data_last_in = 1'b0; flush_in = 1'b0;
    crc32_in = '0; trl_ready_in = 1'b0;
    tick();
    tick();
    check_all_zero("reset");
    rst_n = 1'b1;
    tick();

    // data_last_in without data_valid_in does not end a stream.
    data_last_in = 1'b1;
    tick();
    data_last_in = 1'b0;
    check("last_alone_busy", busy_out, 0);
    tick();

    send_stream("digits", 10, 1'b0, 32'hA684C7C6);
    collect("digits", 8, 0, -1, 64'h0000000A_A684C7C6, 64'h0000000A_A684C7C6);

    send_stream("fox", 43, 1'b0, 32'h414FA339);
    collect("fox", 8, 0, -1, 64'h0000002B_414FA339, 64'h0000002B_414FA339);

    send_stream("ff32", 32, 1'b0, 32'hFF6CAB0B);
    collect("ff32", 8, 1, -1, 64'h00000020_FF6CAB0B, 64'h00000020_FF6CAB0B);

    send_stream("flush", 0, 1'b0, 32'h00000000);
    collect("flush", 8, 0, -1, 64'h0, 64'h0);
    check("err_clean", protocol_err_out, 0);

    // Stray byte during EMIT: trailer intact, sticky error.
    send_stream("inject", 32, 1'b0, 32'h190A55AD);
    collect("inject", 8, 0, 2, 64'h00000020_190A55AD, 64'h00000020_190A55AD);
    check("err_set", protocol_err_out, 1);

    // flush_in on a strobed byte acts as last.
    send_stream("flushlast", 3, 1'b1, 32'hDEADBEEF);
    collect("flushlast", 8, 0, -1, 64'h00000003_DEADBEEF, 64'h00000003_DEADBEEF);
    check("err_sticky", protocol_err_out, 1);

    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("err_cleared", protocol_err_out, 0);

    // 257 bytes: 8-bit counter wraps to 1.
    send_stream("wrap", 257, 1'b0, 32'h12345678);
    collect("wrap", 8, 0, -1, 64'h00000101_12345678, 64'h00000001_12345678);

    // Reset mid-EMIT after three bytes, then a one-byte stream.
    send_stream("midrst", 5, 1'b0, 32'hCAFEF00D);
    collect("midrst", 3, 0, -1, 64'h00000000_00FEF00D, 64'h00000000_00FEF00D);
    check("midrst_valid_before", trl_valid_out, 1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check_all_zero("midrst");
    send_stream("one", 1, 1'b0, 32'h01020304);
    collect("one", 8, 0, -1, 64'h00000001_01020304, 64'h00000001_01020304);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
